// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin single-port RAM arbiter for fetch/data ports (req/ready) onto one bus (en/ack) with timeout, error flag and stall request
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ready,
  input  logic        data_req,
  input  logic        data_write_en,
  input  logic [3:0]  data_write_sel,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_write_data,
  output logic [31:0] data_rdata,
  output logic        data_ready,
  output logic        bus_en,
  output logic        bus_write_en,
  output logic [3:0]  bus_write_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_write_data,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_error,
  output logic        stall_request
);
  typedef enum logic [1:0] {IDLE, INST, DATA, RESP} state_t;
  state_t state, state_n;
  logic last_data, pick_data, store, expired, done;
  logic [7:0] cnt;
  assign stall_request = (inst_req & ~inst_ready) | (data_req & ~data_ready);
  always_comb begin
    pick_data = data_req & ~(inst_req & last_data);
    store = pick_data & data_write_en;
    expired = cnt == 8'(TIMEOUT - 1);
    done = bus_ack | expired;
    state_n = state;
    case (state)
      IDLE: state_n = pick_data ? DATA : inst_req ? INST : IDLE;
      INST, DATA: state_n = done ? RESP : state;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_data <= 1'b0;
      cnt <= '0;
      bus_en <= 1'b0;
      bus_write_en <= 1'b0;
      bus_write_sel <= '0;
      bus_addr <= '0;
      bus_write_data <= '0;
      inst_rdata <= '0;
      data_rdata <= '0;
      inst_ready <= 1'b0;
      data_ready <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      state <= state_n;
      inst_ready <= 1'b0;
      data_ready <= 1'b0;
      case (state)
        IDLE: if (state_n != IDLE) begin
          bus_en <= 1'b1;
          cnt <= '0;
          bus_addr <= pick_data ? data_addr : inst_addr;
          bus_write_en <= store;
          bus_write_sel <= store ? data_write_sel : 4'd0;
          bus_write_data <= store ? data_write_data : 32'd0;
        end
        INST, DATA: begin
          cnt <= cnt + 8'd1;
          if (done) begin
            bus_en <= 1'b0;
            bus_error <= ~bus_ack;
            inst_ready <= state == INST;
            data_ready <= state == DATA;
            if (state == INST) inst_rdata <= bus_ack ? bus_rdata : 32'd0;
            else data_rdata <= (bus_ack & ~bus_write_en) ? bus_rdata : 32'd0;
          end
        end
        default: last_data <= data_ready;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, corner sequences and random rounds against a transaction-level model
module tb_mem_arbiter;
  localparam int TO = 4;
  localparam int NEVER = 255;
  logic clk = 1'b0;
  logic rst;
  logic inst_req, data_req, data_write_en;
  logic [31:0] inst_addr, data_addr, data_write_data;
  logic [3:0] data_write_sel;
  logic [31:0] inst_rdata, data_rdata, bus_addr, bus_write_data, bus_rdata;
  logic inst_ready, data_ready, bus_en, bus_write_en, bus_ack, bus_error, stall_request;
  logic [3:0] bus_write_sel;
  always #5 clk = ~clk;
  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
    .data_req(data_req), .data_write_en(data_write_en), .data_write_sel(data_write_sel),
    .data_addr(data_addr), .data_write_data(data_write_data), .data_rdata(data_rdata), .data_ready(data_ready),
    .bus_en(bus_en), .bus_write_en(bus_write_en), .bus_write_sel(bus_write_sel), .bus_addr(bus_addr),
    .bus_write_data(bus_write_data), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_error(bus_error),
    .stall_request(stall_request)
  );
  int total = 0, bad = 0;
  int ack_delay = NEVER;
  bit m_last = 1'b0;
  logic [31:0] r_iaddr, r_daddr, r_wd;
  logic r_we;
  logic [3:0] r_sel;
  int o_lat[2], o_pul[2], o_ord[2], b_en[2];
  logic [31:0] o_rd[2], b_addr[2], b_wd[2];
  logic o_er[2], b_we[2];
  logic [3:0] b_sel[2];
  typedef struct {
    bit dp; bit we; logic [3:0] sel; logic [31:0] addr; logic [31:0] wd;
    int k; int lat; logic [31:0] rd; bit err;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 32'h40 ? 32'h2402_0005 : {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h0101};
  endfunction
  initial begin
    int n;
    n = 0;
    bus_ack = 1'b0;
    bus_rdata = 32'hBAD0_BAD0;
    forever begin
      @(posedge clk); #1;
      if (bus_en) begin
        bus_ack = n == ack_delay;
        bus_rdata = bus_ack ? mem_word(bus_addr) : 32'hBAD0_BAD0;
        n++;
      end else begin
        bus_ack = 1'b0;
        n = 0;
      end
    end
  end
  task automatic setup(input logic [31:0] ia, input logic [31:0] da, input bit we,
                       input logic [3:0] sel, input logic [31:0] wd, input int k);
    inst_addr = ia; data_addr = da; data_write_en = we; data_write_sel = sel; data_write_data = wd;
    ack_delay = k;
    r_iaddr = ia; r_daddr = da; r_we = we; r_sel = sel; r_wd = wd;
  endtask
  task automatic zero_check(input string tag);
    chk({tag, "_bus_en"}, 32'(bus_en), 0);
    chk({tag, "_inst_ready"}, 32'(inst_ready), 0);
    chk({tag, "_data_ready"}, 32'(data_ready), 0);
    chk({tag, "_bus_error"}, 32'(bus_error), 0);
    chk({tag, "_bus_addr"}, bus_addr, 0);
    chk({tag, "_bus_we"}, 32'(bus_write_en), 0);
    chk({tag, "_bus_sel"}, 32'(bus_write_sel), 0);
    chk({tag, "_bus_wdata"}, bus_write_data, 0);
    chk({tag, "_inst_rdata"}, inst_rdata, 0);
    chk({tag, "_data_rdata"}, data_rdata, 0);
  endtask
  task automatic do_round(input bit ion, input bit don, input int drop_at);
    bit wt[2];
    bit prev_en;
    int ns, nr, quiet, drift;
    logic [31:0] s_addr[2], s_wd[2];
    logic s_we[2];
    logic [3:0] s_sel[2];
    int s_en[2];
    ns = 0; nr = 0; quiet = 0; drift = 0; prev_en = 0;
    for (int p = 0; p < 2; p++) begin
      s_en[p] = 0; o_pul[p] = 0; o_ord[p] = -1; o_lat[p] = -1; o_rd[p] = 'x; o_er[p] = 'x;
      b_addr[p] = 'x; b_wd[p] = 'x; b_we[p] = 'x; b_sel[p] = 'x; b_en[p] = -1;
    end
    wt[0] = ion; wt[1] = don;
    inst_req = ion; data_req = don;
    for (int c = 1; c <= 80 && quiet < 3; c++) begin
      @(posedge clk); #1;
      chk("stall", 32'(stall_request), 32'((inst_req & ~inst_ready) | (data_req & ~data_ready)));
      if (bus_en && !prev_en && ns < 2) begin
        s_addr[ns] = bus_addr; s_wd[ns] = bus_write_data; s_we[ns] = bus_write_en; s_sel[ns] = bus_write_sel;
        ns++;
      end else if (bus_en && ns > 0 && bus_addr !== s_addr[ns-1]) drift++;
      if (bus_en && ns > 0) s_en[ns-1]++;
      prev_en = bus_en;
      if (c == drop_at) begin
        inst_req = 0;
        inst_addr = ~inst_addr;
      end
      if (inst_ready) begin
        o_pul[0]++; o_lat[0] = c; o_rd[0] = inst_rdata; o_er[0] = bus_error;
        if (nr < 2) o_ord[nr] = 0;
        nr++; inst_req = 0; wt[0] = 0;
      end
      if (data_ready) begin
        o_pul[1]++; o_lat[1] = c; o_rd[1] = data_rdata; o_er[1] = bus_error;
        if (nr < 2) o_ord[nr] = 1;
        nr++; data_req = 0; wt[1] = 0;
      end
      if (!wt[0] && !wt[1]) quiet++;
    end
    chk("round_done", 32'({wt[0], wt[1]}), 0);
    chk("bus_addr_stable", 32'(drift), 0);
    for (int s = 0; s < ns && s < nr && s < 2; s++) begin
      b_addr[o_ord[s]] = s_addr[s]; b_wd[o_ord[s]] = s_wd[s];
      b_we[o_ord[s]] = s_we[s]; b_sel[o_ord[s]] = s_sel[s]; b_en[o_ord[s]] = s_en[s];
    end
  endtask
  task automatic check_model(input bit ion, input bit don, input int k);
    int ke = k < TO ? k : TO - 1;
    bit tmo = k >= TO;
    int t = 0;
    int first = (ion && don) ? (m_last ? 0 : 1) : (don ? 1 : 0);
    for (int n = 0; n < int'(ion) + int'(don); n++) begin
      int p = n == 0 ? first : 1 - first;
      bit st = p == 1 && r_we;
      logic [31:0] a = p == 1 ? r_daddr : r_iaddr;
      t += 2 + ke;
      chk("order", o_ord[n], p);
      chk("latency", o_lat[p], t);
      chk("pulses", o_pul[p], 1);
      chk("rdata", o_rd[p], (tmo || st) ? 32'd0 : mem_word(a));
      chk("error", 32'(o_er[p]), 32'(tmo));
      chk("bus_addr", b_addr[p], a);
      chk("bus_we", 32'(b_we[p]), 32'(st));
      chk("bus_sel", 32'(b_sel[p]), st ? 32'(r_sel) : 0);
      chk("bus_wdata", b_wd[p], st ? r_wd : 0);
      chk("bus_en_cycles", b_en[p], ke + 1);
      t += 1;
      m_last = p[0];
    end
    if (!ion) chk("inst_idle", o_pul[0], 0);
    if (!don) chk("data_idle", o_pul[1], 0);
  endtask
  task automatic run(input bit ion, input bit don, input int drop_at);
    do_round(ion, don, drop_at);
    check_model(ion, don, ack_delay);
  endtask
  initial begin
    int pulses;
    tbl[0] = '{0, 0, 4'h0, 32'h40, 32'h0, 2, 4, 32'h2402_0005, 0};
    tbl[1] = '{1, 1, 4'b0011, 32'h100, 32'hDEAD_BEEF, 0, 2, 32'h0, 0};
    tbl[2] = '{1, 0, 4'h0, 32'h200, 32'h0, NEVER, 5, 32'h0, 1};
    tbl[3] = '{1, 0, 4'h0, 32'h204, 32'h0, 3, 5, 32'h585E_0101, 0};
    tbl[4] = '{0, 0, 4'h0, 32'h1000, 32'h0, 1, 3, 32'h4A5A_0101, 0};
    tbl[5] = '{1, 1, 4'hF, 32'h300, 32'h1234_5678, NEVER, 5, 32'h0, 1};
    rst = 1;
    inst_req = 0; data_req = 0;
    setup(0, 0, 0, 0, 0, NEVER);
    repeat (2) @(posedge clk);
    #1;
    zero_check("reset");
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      setup(tbl[i].addr, tbl[i].addr, tbl[i].we, tbl[i].sel, tbl[i].wd, tbl[i].k);
      run(!tbl[i].dp, tbl[i].dp, 0);
      chk("vec_latency", o_lat[tbl[i].dp], tbl[i].lat);
      chk("vec_rdata", o_rd[tbl[i].dp], tbl[i].rd);
      chk("vec_error", 32'(o_er[tbl[i].dp]), 32'(tbl[i].err));
      chk("vec_bus_addr", b_addr[tbl[i].dp], tbl[i].addr);
      chk("vec_bus_we", 32'(b_we[tbl[i].dp]), 32'(tbl[i].we & tbl[i].dp));
    end
    setup(32'h80, 32'h0, 0, 0, 0, 1);
    run(1, 0, 2);
    chk("drop_latency", o_lat[0], 3);
    setup(32'h0, 32'h300, 0, 0, 0, NEVER);
    data_req = 1;
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_bus_en", 32'(bus_en), 1);
    rst = 1;
    @(posedge clk); #1;
    data_req = 0;
    zero_check("mid_reset");
    @(posedge clk); #1;
    rst = 0;
    m_last = 0;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (inst_ready || data_ready) pulses++;
    end
    chk("no_ready_after_reset", pulses, 0);
    setup(32'h44, 32'h0, 0, 0, 0, 0);
    run(1, 0, 0);
    m_last = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    setup(32'h48, 32'h500, 1, 4'hC, 32'hCAFE_F00D, 1);
    run(1, 1, 0);
    chk("tie_first_data", o_ord[0], 1);
    chk("tie_then_inst", o_ord[1], 0);
    setup(32'h4C, 32'h504, 0, 0, 0, 0);
    run(0, 1, 0);
    setup(32'h50, 32'h508, 0, 0, 0, 2);
    run(1, 1, 0);
    chk("tie_alternates_inst", o_ord[0], 0);
    for (int r = 0; r < 40; r++) begin
      int pat = int'($urandom_range(0, 2));
      setup({16'h0, 16'($urandom) & 16'hFFFC}, {16'h1, 16'($urandom) & 16'hFFFC}, 1'($urandom),
            4'($urandom), $urandom, int'($urandom_range(0, 6)));
      run(pat != 1, pat != 0, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
